rvvi_depacketizer: RTL and testbench
====================================

// Module: rvvi_depacketizer
// PURPOSE
//  Receive-side counterpart of the RVVI trace packetizer. Consumes 32-bit AXI-stream beats from the Ethernet MAC RX
//  FIFO and filters on MAC addresses and EtherType. Extracts FrameCount and the RVVI record, and presents each complete,
//  well-formed frame as one record on a valid/ready port. Used in FPGA loopback and host-model benches to reconstruct
//  the trace stream emitted by the DUT-side tracer.
// PARAMETERS
//  RVVI_WIDTH         784  RVVI record width in bits (128+4*XLEN+MAX_CSRS*(XLEN+16) at XLEN=64, MAX_CSRS=5)
//  FRAME_COUNT_WIDTH  64   frame counter width; fixed at 64 (2 beats)
//  CNT_WIDTH          16   width of the error/statistics counters
// PORTS
//  clk            in   1                  clock
//  reset          in   1                  synchronous, active-high reset
//  RvviAxiRdata   in   32                 RX stream data; byte lane 0 = first byte on the wire
//  RvviAxiRstrb   in   4                  RX byte strobes; ignored except as noted below
//  RvviAxiRlast   in   1                  last beat of the Ethernet frame
//  RvviAxiRvalid  in   1                  beat valid
//  RvviAxiRready  out  1                  beat accepted when Rvalid&Rready
//  DstMac         in   48                 expected destination MAC
//  SrcMac         in   48                 expected source MAC
//  EthType        in   16                 expected EtherType (0x005c)
//  RvviValid      out  1                  record valid
//  RvviReady      in   1                  record consumer ready
//  Rvvi           out  RVVI_WIDTH         record; beat k of payload -> Rvvi[32k+31:32k]
//  FrameCount     out  FRAME_COUNT_WIDTH  frame count of the presented record
//  DropCount      out  CNT_WIDTH          frames discarded (header mismatch or runt), saturating
//  SeqErrCount    out  CNT_WIDTH          sequence errors (see CONFIGURATION), saturating
// BEHAVIOUR
//  - Frame layout in beats (wire byte order, network order for header fields):
//    b0 = Dst[47:16]; b1 = {Dst[15:0], Src[47:32]}; b2 = Src[31:0]; b3 = {EthType, 16-bit pad (ignored)}.
//    b4 = FrameCount[31:0], lane0 = LSB; b5 = FrameCount[63:32].
//    b6 .. b6+NW-1 = payload, with NW = ceil(RVVI_WIDTH/32); surplus bits of the last word are dropped.
//  - Header bytes are compared per beat. The expected beat is {byte3,byte2,byte1,byte0}, with byte0 = first wire byte.
//  - States: HDR (beat idx 0..3) -> CNT (idx 4..5) -> PAY (NW beats) -> TAIL -> HDR; DROP is the discard path.
//    - HDR: any beat mismatch -> DROP; a mismatch on a tlast beat -> HDR directly. Each mismatch sets DropCount+1.
//    - PAY: after the final payload beat, tlast=1 -> HDR and present the record. tlast=0 -> TAIL, which discards
//      MAC min-frame padding until tlast, then presents.
//    - Runt: tlast on any beat before the final payload beat -> DropCount+1, HDR, no record, Rvvi unchanged.
//    - DROP: discard beats until a tlast beat is accepted, then HDR.
//  - RvviAxiRready = ~RvviValid, registered state only, no combinational path from RvviReady.
//  - The assembly register is the output register.
//  - RvviValid rises the cycle after the tlast beat is accepted and holds, with Rvvi/FrameCount stable, until
//    RvviValid&RvviReady. It clears on that cycle, so Rready returns 1 the next cycle (1-cycle bubble per frame).
//  - Rstrb: a beat with Rstrb!=4'hF is treated as a runt if it is not tlast, or if it ends before the payload.
//  - Beat index counter width is clog2(6+NW+1). It resets to 0 on HDR entry and never wraps within a frame.
//  - DropCount/SeqErrCount saturate at all-ones, with no wrap.
//  - Reset: state HDR, idx 0, RvviValid 0, RvviAxiRready 1 (first cycle after reset), Rvvi 0, FrameCount 0,
//    counters 0, expected sequence 0.
//    - Reset mid-frame: the remaining beats are parsed as a header, mismatch, and drop until tlast (DropCount+1).
// CONFIGURATION
//  - RVVI_DEPKT_SEQCHK_EN defined:
//    - A frame whose FrameCount != ExpectedCount is discarded, with SeqErrCount+1 and no record.
//    - Every frame that passes the header check sets ExpectedCount = FrameCount+1 (resync).
//    - The first frame after reset is always accepted.
//  - RVVI_DEPKT_SEQCHK_EN undefined: no check, SeqErrCount tied to 0, no ExpectedCount register.
// TESTING
//  T1 good frame:
//     - Stimulus: NW payload beats with valid header, FrameCount=0x5, RvviReady=1.
//     - Response: RvviValid 1 cycle after tlast, FrameCount=5, Rvvi matches, DropCount=0.
//  T2 MAC mismatch:
//     - Stimulus: b0 with Dst byte0 flipped.
//     - Response: all beats discarded, DropCount=1, no RvviValid, then a following good frame is delivered.
//  T3 runt and padding:
//     - Stimulus: tlast on b4.
//     - Response: DropCount+1.
//     - Stimulus: good frame with 3 trailing pad beats.
//     - Response: record delivered only after the pad tlast.
//  T4 backpressure:
//     - Stimulus: RvviReady=0 for 10 cycles with the next frame queued.
//     - Response: Rready=0, outputs stable; record consumed when Ready=1; Rready=1 the next cycle.
//  T5 reset mid-PAY:
//     - Stimulus: reset mid-PAY, then the remainder of the frame followed by a good frame.
//     - Response: DropCount=1, second frame delivered.
//  T6 (SEQCHK_EN) sequence gap:
//     - Stimulus: FrameCounts 0,1,3.
//     - Response: frames 0 and 1 delivered, 3 dropped, SeqErrCount=1; then frame 4 delivered.

Source files
------------

// File: rtl/rvvi_depacketizer.sv
// rvvi_depacketizer: receive side of the RVVI trace link.
// Parses 32-bit AXI-stream beats from the MAC RX FIFO, checks the Ethernet header against DstMac/SrcMac/EthType,
// extracts the 64-bit FrameCount and the RVVI payload, and presents each complete frame as one record.
// Optional build macro: RVVI_DEPKT_SEQCHK_EN enables FrameCount sequence checking (SeqErrCount / ExpectedCount).
// DbgState mirrors the parser state: 0=HDR 1=CNT 2=PAY 3=TAIL 4=DROP.
//
// Handshakes: a beat transfers on a clock edge where RvviAxiRvalid & RvviAxiRready are both 1; a record transfers on
// an edge where RvviValid & RvviReady are both 1. RvviAxiRready is ~RvviValid (registered only), and RvviValid plus
// Rvvi/FrameCount hold steady from the cycle after the final tlast beat until the record transfer.
module rvvi_depacketizer #(
  parameter int RVVI_WIDTH        = 784,
  parameter int FRAME_COUNT_WIDTH = 64,
  parameter int CNT_WIDTH         = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [31:0]                  RvviAxiRdata,
  input  logic [3:0]                   RvviAxiRstrb,
  input  logic                         RvviAxiRlast,
  input  logic                         RvviAxiRvalid,
  output logic                         RvviAxiRready,
  input  logic [47:0]                  DstMac,
  input  logic [47:0]                  SrcMac,
  input  logic [15:0]                  EthType,
  output logic                         RvviValid,
  input  logic                         RvviReady,
  output logic [RVVI_WIDTH-1:0]        Rvvi,
  output logic [FRAME_COUNT_WIDTH-1:0] FrameCount,
  output logic [CNT_WIDTH-1:0]         DropCount,
  output logic [CNT_WIDTH-1:0]         SeqErrCount,
  output logic [2:0]                   DbgState
);

  // Payload words per frame; the surplus bits of the last word are dropped.
  localparam int NW    = (RVVI_WIDTH + 31) / 32;
  localparam int IDX_W = $clog2(6 + NW + 1);
  localparam logic [IDX_W-1:0] PAY_FIRST = IDX_W'(6);
  localparam logic [IDX_W-1:0] PAY_LAST  = IDX_W'(6 + NW - 1);

  typedef enum logic [2:0] {
    HDR  = 3'd0,
    CNT  = 3'd1,
    PAY  = 3'd2,
    TAIL = 3'd3,
    DROP = 3'd4
  } state_t;

  state_t           state, stateNext;
  logic [IDX_W-1:0] idx, idxNext;
  logic             beatAcc;
  logic             fullStrb;
  logic [31:0]      hdrExp, hdrMask;
  logic             hdrMatch;
  logic             dropInc;
  logic             setValid;
  logic             wrCntLo, wrCntHi, wrPay;
  logic [IDX_W-1:0] payK;
  logic [NW*32-1:0] payWide, payMerged;

  assign RvviAxiRready = ~RvviValid;
  assign beatAcc       = RvviAxiRvalid & RvviAxiRready;
  assign fullStrb      = &RvviAxiRstrb;
  assign DbgState      = state;

  // Expected header beat for the current index; wire byte 0 sits in lane 0, the EtherType pad is masked off.
  always_comb begin
    hdrExp  = '0;
    hdrMask = 32'hFFFF_FFFF;
    case (idx)
      IDX_W'(0): hdrExp = {DstMac[23:16], DstMac[31:24], DstMac[39:32], DstMac[47:40]};
      IDX_W'(1): hdrExp = {SrcMac[39:32], SrcMac[47:40], DstMac[7:0], DstMac[15:8]};
      IDX_W'(2): hdrExp = {SrcMac[7:0], SrcMac[15:8], SrcMac[23:16], SrcMac[31:24]};
      IDX_W'(3): begin
        hdrExp  = {16'h0000, EthType[7:0], EthType[15:8]};
        hdrMask = 32'h0000_FFFF;
      end
      default: ;
    endcase
  end

  assign hdrMatch = ((RvviAxiRdata ^ hdrExp) & hdrMask) == 32'h0;

  // Merge the incoming payload word into a word-padded copy of the record register.
  always_comb begin
    payK                      = (idx >= PAY_FIRST) ? (idx - PAY_FIRST) : '0;
    payWide                   = '0;
    payWide[RVVI_WIDTH-1:0]   = Rvvi;
    payMerged                 = payWide;
    payMerged[{payK, 5'd0} +: 32] = RvviAxiRdata;
  end

`ifdef RVVI_DEPKT_SEQCHK_EN
  logic [63:0] expectedCount;
  logic        seqSeen;
  logic        seqBad;
  logic        seqErrInc;
  logic        cntDone;
  assign seqBad = seqSeen && ({RvviAxiRdata, FrameCount[31:0]} != expectedCount);
`endif

  // Parser next-state and per-beat actions.
  always_comb begin
    stateNext = state;
    idxNext   = idx;
    dropInc   = 1'b0;
    setValid  = 1'b0;
    wrCntLo   = 1'b0;
    wrCntHi   = 1'b0;
    wrPay     = 1'b0;
`ifdef RVVI_DEPKT_SEQCHK_EN
    seqErrInc = 1'b0;
    cntDone   = 1'b0;
`endif
    if (beatAcc) begin
      case (state)
        HDR: begin
          // A bad header beat or a frame ending inside the header is one drop.
          if (!hdrMatch || RvviAxiRlast || !fullStrb) begin
            dropInc   = 1'b1;
            stateNext = RvviAxiRlast ? HDR : DROP;
            idxNext   = '0;
          end else begin
            idxNext = idx + 1'b1;
            if (idx == IDX_W'(3)) stateNext = CNT;
          end
        end
        CNT: begin
          if (RvviAxiRlast || !fullStrb) begin
            dropInc   = 1'b1;
            stateNext = RvviAxiRlast ? HDR : DROP;
            idxNext   = '0;
          end else if (idx == IDX_W'(4)) begin
            wrCntLo = 1'b1;
            idxNext = idx + 1'b1;
          end else begin
            wrCntHi = 1'b1;
`ifdef RVVI_DEPKT_SEQCHK_EN
            cntDone = 1'b1;
            if (seqBad) begin
              seqErrInc = 1'b1;
              stateNext = DROP;
              idxNext   = '0;
            end else
`endif
            begin
              idxNext   = idx + 1'b1;
              stateNext = PAY;
            end
          end
        end
        PAY: begin
          // Early tlast, or a partial beat that does not end the payload, truncates the frame.
          if ((idx != PAY_LAST && (RvviAxiRlast || !fullStrb)) ||
              (idx == PAY_LAST && !RvviAxiRlast && !fullStrb)) begin
            dropInc   = 1'b1;
            stateNext = RvviAxiRlast ? HDR : DROP;
            idxNext   = '0;
          end else begin
            wrPay = 1'b1;
            if (idx == PAY_LAST) begin
              if (RvviAxiRlast) begin
                setValid  = 1'b1;
                stateNext = HDR;
                idxNext   = '0;
              end else begin
                stateNext = TAIL;
              end
            end else begin
              idxNext = idx + 1'b1;
            end
          end
        end
        TAIL: begin
          // Minimum-frame padding after the payload is discarded; the record goes out on tlast.
          if (RvviAxiRlast) begin
            setValid  = 1'b1;
            stateNext = HDR;
            idxNext   = '0;
          end else if (!fullStrb) begin
            dropInc   = 1'b1;
            stateNext = DROP;
            idxNext   = '0;
          end
        end
        DROP: begin
          if (RvviAxiRlast) begin
            stateNext = HDR;
            idxNext   = '0;
          end
        end
        default: begin
          stateNext = HDR;
          idxNext   = '0;
        end
      endcase
    end
  end

  // Parser state and beat index registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= HDR;
      idx   <= '0;
    end else begin
      state <= stateNext;
      idx   <= idxNext;
    end
  end

  // Record assembly directly in the output registers; the beat port is closed while a record is pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      RvviValid  <= 1'b0;
      Rvvi       <= '0;
      FrameCount <= '0;
    end else begin
      if (setValid) RvviValid <= 1'b1;
      else if (RvviValid && RvviReady) RvviValid <= 1'b0;
      if (wrCntLo) FrameCount[31:0]  <= RvviAxiRdata;
      if (wrCntHi) FrameCount[63:32] <= RvviAxiRdata;
      if (wrPay)   Rvvi              <= payMerged[RVVI_WIDTH-1:0];
    end
  end

  // Saturating count of discarded frames.
  always_ff @(posedge clk) begin
    if (reset) DropCount <= '0;
    else if (dropInc && (DropCount != '1)) DropCount <= DropCount + 1'b1;
  end

`ifdef RVVI_DEPKT_SEQCHK_EN
  // Sequence tracking: resync on every frame that passes the header, count gaps after the first frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      expectedCount <= '0;
      seqSeen       <= 1'b0;
      SeqErrCount   <= '0;
    end else begin
      if (cntDone) begin
        expectedCount <= {RvviAxiRdata, FrameCount[31:0]} + 64'd1;
        seqSeen       <= 1'b1;
      end
      if (seqErrInc && (SeqErrCount != '1)) SeqErrCount <= SeqErrCount + 1'b1;
    end
  end
`else
  assign SeqErrCount = '0;
`endif

endmodule

// File: tb/tb_rvvi_depacketizer.sv
// Directed bench for rvvi_depacketizer: good frames, header mismatch, runt, padding, backpressure,
// reset mid-payload and (with RVVI_DEPKT_SEQCHK_EN) a sequence gap.
module tb_rvvi_depacketizer;

  localparam int RW    = 784;
  localparam int NW    = 25;
  localparam int CW    = 16;
  localparam int REC_W = RW + 64;
`ifdef RVVI_DEPKT_SEQCHK_EN
  localparam int SEQ_ON = 1;
`else
  localparam int SEQ_ON = 0;
`endif

  logic          clk;
  logic          reset;
  logic [31:0]   RvviAxiRdata;
  logic [3:0]    RvviAxiRstrb;
  logic          RvviAxiRlast;
  logic          RvviAxiRvalid;
  logic          RvviAxiRready;
  logic [47:0]   DstMac  = 48'h02_11_22_33_44_55;
  logic [47:0]   SrcMac  = 48'h02_AA_BB_CC_DD_EE;
  logic [15:0]   EthType = 16'h005c;
  logic          RvviValid;
  logic          RvviReady;
  logic [RW-1:0] Rvvi;
  logic [63:0]   FrameCount;
  logic [CW-1:0] DropCount;
  logic [CW-1:0] SeqErrCount;
  logic [2:0]    DbgState;

  logic [REC_W-1:0] exp_q[$];
  int n_checks  = 0;
  int n_fail    = 0;
  int rec_count = 0;

  rvvi_depacketizer #(.RVVI_WIDTH(RW), .FRAME_COUNT_WIDTH(64), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .RvviAxiRdata(RvviAxiRdata), .RvviAxiRstrb(RvviAxiRstrb), .RvviAxiRlast(RvviAxiRlast),
    .RvviAxiRvalid(RvviAxiRvalid), .RvviAxiRready(RvviAxiRready),
    .DstMac(DstMac), .SrcMac(SrcMac), .EthType(EthType),
    .RvviValid(RvviValid), .RvviReady(RvviReady), .Rvvi(Rvvi), .FrameCount(FrameCount),
    .DropCount(DropCount), .SeqErrCount(SeqErrCount), .DbgState(DbgState)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [REC_W-1:0] got, input logic [REC_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pay_word(input logic [63:0] fc, input int k);
    logic [7:0]  kb;
    logic [15:0] kw;
    kb = 8'(k);
    kw = 16'(k);
    return {fc[7:0], kb, 16'hC3A5 ^ kw};
  endfunction

  function automatic logic [RW-1:0] exp_rvvi(input logic [63:0] fc);
    logic [NW*32-1:0] w;
    w = '0;
    for (int k = 0; k < NW; k++) w[k*32 +: 32] = pay_word(fc, k);
    return w[RW-1:0];
  endfunction

  // Beat i of a frame; header words are the hand-packed wire images of the MACs and EtherType.
  function automatic logic [31:0] beat_word(input logic [63:0] fc, input int i, input logic [31:0] flip);
    if (i == 0) return 32'h3322_1102 ^ flip;
    if (i == 1) return 32'hAA02_5544;
    if (i == 2) return 32'hEEDD_CCBB;
    if (i == 3) return 32'hBEEF_5C00;
    if (i == 4) return fc[31:0];
    if (i == 5) return fc[63:32];
    if (i < 6 + NW) return pay_word(fc, i - 6);
    return 32'h0;
  endfunction

  task automatic push_exp(input logic [63:0] fc);
    exp_q.push_back({fc, exp_rvvi(fc)});
  endtask

  // Present one beat from a negedge and hold it until it is accepted on a rising edge.
  task automatic put_beat(input logic [31:0] d, input logic l, input logic [3:0] s);
    int n;
    n = 0;
    @(negedge clk);
    RvviAxiRdata  = d;
    RvviAxiRlast  = l;
    RvviAxiRstrb  = s;
    RvviAxiRvalid = 1'b1;
    while (!RvviAxiRready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_eq("beat_accept_timeout", n, 0);
    @(posedge clk);
    #1;
    RvviAxiRvalid = 1'b0;
    RvviAxiRlast  = 1'b0;
  endtask

  task automatic send_beats(input logic [63:0] fc, input logic [31:0] flip, input int first, input int last_i,
                            input logic with_last);
    for (int i = first; i <= last_i; i++) begin
      logic l;
      l = with_last && (i == last_i);
      put_beat(beat_word(fc, i, flip), l, (l && i == 6 + NW - 1) ? 4'h3 : 4'hF);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard: every record transfer is compared against the head of exp_q.
  always @(negedge clk) begin
    if (!reset && RvviValid && RvviReady) begin
      logic [REC_W-1:0] e;
      check_eq("record_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("rec_framecount", FrameCount, e[REC_W-1 -: 64]);
        check_eq("rec_rvvi", Rvvi, e[RW-1:0]);
        rec_count++;
      end
    end
  end

  initial begin
    int exp_recs;
    reset         = 1'b1;
    RvviAxiRdata  = '0;
    RvviAxiRstrb  = 4'hF;
    RvviAxiRlast  = 1'b0;
    RvviAxiRvalid = 1'b0;
    RvviReady     = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    // Reset state
    check_eq("rst_valid", RvviValid, 0);
    check_eq("rst_rready", RvviAxiRready, 1);
    check_eq("rst_dropcount", DropCount, 0);
    check_eq("rst_seqerr", SeqErrCount, 0);
    check_eq("rst_framecount", FrameCount, 0);
    check_eq("rst_rvvi", Rvvi, 0);
    check_eq("rst_state", DbgState, 0);
    RvviReady = 1'b1;

    // T1 good frame
    push_exp(64'h5);
    send_beats(64'h5, 32'h0, 0, 30, 1'b1);
    @(negedge clk);
    check_eq("t1_valid_after_tlast", RvviValid, 1);
    idle(3);
    check_eq("t1_dropcount", DropCount, 0);
    check_eq("t1_valid_cleared", RvviValid, 0);
    check_eq("t1_rready_back", RvviAxiRready, 1);

    // T2 MAC mismatch, then a good frame
    send_beats(64'h6, 32'h0000_0001, 0, 30, 1'b1);
    idle(3);
    check_eq("t2_dropcount", DropCount, 1);
    check_eq("t2_no_valid", RvviValid, 0);
    check_eq("t2_state_hdr", DbgState, 0);
    push_exp(64'h6);
    send_beats(64'h6, 32'h0, 0, 30, 1'b1);
    idle(3);
    check_eq("t2_records", rec_count, 2);

    // T3 runt on b4, then a padded good frame
    send_beats(64'h7, 32'h0, 0, 4, 1'b1);
    idle(2);
    check_eq("t3_runt_drop", DropCount, 2);
    check_eq("t3_runt_state", DbgState, 0);
    push_exp(64'h7);
    send_beats(64'h7, 32'h0, 0, 30, 1'b0);
    @(negedge clk);
    check_eq("t3_no_valid_before_pad", RvviValid, 0);
    check_eq("t3_state_tail", DbgState, 3);
    send_beats(64'h7, 32'h0, 31, 33, 1'b1);
    @(negedge clk);
    check_eq("t3_valid_after_pad", RvviValid, 1);
    idle(3);
    check_eq("t3_records", rec_count, 3);
    check_eq("t3_dropcount", DropCount, 2);

    // T4 backpressure with the next frame queued
    @(posedge clk);
    #1 RvviReady = 1'b0;
    push_exp(64'h8);
    send_beats(64'h8, 32'h0, 0, 30, 1'b1);
    push_exp(64'h9);
    fork
      send_beats(64'h9, 32'h0, 0, 30, 1'b1);
      begin
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          check_eq("t4_valid_hold", RvviValid, 1);
          check_eq("t4_rready_low", RvviAxiRready, 0);
          check_eq("t4_fc_hold", FrameCount, 64'h8);
          check_eq("t4_rvvi_hold", Rvvi, exp_rvvi(64'h8));
        end
        @(posedge clk);
        #1 RvviReady = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("t4_rready_after", RvviAxiRready, 1);
      end
    join
    idle(3);
    check_eq("t4_records", rec_count, 5);

    // T5 reset in the middle of the payload
    send_beats(64'hA, 32'h0, 0, 14, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("t5_drop_after_reset", DropCount, 0);
    check_eq("t5_state_after_reset", DbgState, 0);
    send_beats(64'hA, 32'h0, 15, 30, 1'b1);
    idle(2);
    check_eq("t5_dropcount", DropCount, 1);
    push_exp(64'hB);
    send_beats(64'hB, 32'h0, 0, 30, 1'b1);
    idle(3);
    check_eq("t5_records", rec_count, 6);

    // T6 sequence gap: 12, 13, 15, 16
    push_exp(64'hC);
    send_beats(64'hC, 32'h0, 0, 30, 1'b1);
    push_exp(64'hD);
    send_beats(64'hD, 32'h0, 0, 30, 1'b1);
    if (SEQ_ON == 0) push_exp(64'hF);
    send_beats(64'hF, 32'h0, 0, 30, 1'b1);
    push_exp(64'h10);
    send_beats(64'h10, 32'h0, 0, 30, 1'b1);
    idle(4);
    exp_recs = (SEQ_ON != 0) ? 9 : 10;
    check_eq("t6_seqerr", SeqErrCount, SEQ_ON);
    check_eq("t6_records", rec_count, exp_recs);
    check_eq("t6_dropcount", DropCount, 1);
    check_eq("exp_q_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
